traffic_light_ctrl_param: RTL and testbench
===========================================

TRAFFIC_LIGHT_CTRL_PARAM -- requirements
Module: traffic_light_ctrl_param

Interface
REQ-001 Parameter: CNT_W, 12, phase counter width in bits.
REQ-002 Parameter: T_GREEN1, 2500, green duration for road 1, in cycles.
REQ-003 Parameter: T_GREEN2, 2250, green duration for road 2, in cycles.
REQ-004 Parameter: T_YELLOW, 250, yellow duration for both roads, in cycles.
REQ-005 Parameter: T_ALLRED, 50, all-red clearance duration, in cycles.
REQ-006 Parameter: T_WALK, 400, pedestrian walk duration, in cycles.
REQ-007 Parameter: T_FLASH, 500, night-mode flash half-period, in cycles.
REQ-008 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-009 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-010 Port: night_mode, input, 1, level request for flashing-yellow operation.
REQ-011 Port: ped_req, input, 1, single-cycle or level pedestrian request.
REQ-012 Port: light1, output, 3, road-1 lamps as {red,yellow,green}, registered.
REQ-013 Port: light2, output, 3, road-2 lamps as {red,yellow,green}, registered.
REQ-014 Port: ped_walk, output, 1, pedestrian walk lamp, registered.
REQ-015 Port: phase, output, 3, current state encoding, registered.

Function
REQ-016 The states and their phase codes SHALL be INIT=0, G1R2=1, Y1R2=2, AR1=3, R1G2=4, R1Y2=5, AR2=6, WALK=7, and FLASH, with FLASH sharing code 0 and distinguished from INIT by the flash bit.
REQ-017 Outputs SHALL be Moore: light1 and light2 SHALL be G1R2 001/100, Y1R2 010/100, AR1/AR2/WALK 100/100, R1G2 100/001, R1Y2 100/010, INIT 010/010.
REQ-018 Exactly one lamp per road SHALL be lit in every state except FLASH-off, where both roads are 000.
REQ-019 Each timed state SHALL last exactly its T_* cycles: count is 1 on entry, increments each cycle, and exits at count==T with count reloaded to 1.
REQ-020 INIT SHALL last one cycle, then enter G1R2.
REQ-021 The normal sequence SHALL be G1R2 -> Y1R2 -> AR1 -> R1G2 -> R1Y2 -> AR2 -> G1R2.
REQ-022 night_mode SHALL be sampled only on the last cycle of AR1 or AR2; if it is 1, the next state SHALL be FLASH instead of the normal successor.
REQ-023 In FLASH, both yellows SHALL toggle together every T_FLASH cycles, starting lit, with red and green at 0.
REQ-024 When night_mode is 0 on the last cycle of a flash half-period, the next state SHALL be AR1 for the full T_ALLRED, followed by R1G2.
REQ-025 ped_walk SHALL be 1 only in WALK.
REQ-026 A parameter set SHALL be rejected at elaboration if any T_* is 0 or is 2**CNT_W or greater.

Reset
REQ-027 While reset_n is 0, the block SHALL asynchronously force: state INIT, count 0, light1=light2=010, ped_walk 0, phase 0, pedestrian latch 0, flash bit 0.
REQ-028 Reset deassertion mid-phase SHALL restart the block at INIT, and no partial phase SHALL resume.

Configuration
REQ-029 With macro TLC_PED_REQ_EN defined, a 1 on ped_req in any cycle SHALL set a pending latch, and the latch SHALL be ignored while in WALK.
REQ-030 With TLC_PED_REQ_EN defined, the last cycle of AR2 with the latch set and night_mode 0 SHALL go to WALK, clear the latch, and return to G1R2 after T_WALK cycles.
REQ-031 If night_mode and the pending latch are both set at the end of AR2, FLASH SHALL take priority and the latch SHALL be kept.
REQ-032 Without TLC_PED_REQ_EN, ped_req SHALL be ignored, ped_walk SHALL be tied to 0, and WALK SHALL be unreachable.

Verification
REQ-033 Bench parameters SHALL be T_GREEN1=5, T_GREEN2=4, T_YELLOW=2, T_ALLRED=1, T_WALK=3, T_FLASH=2, CNT_W=4.
REQ-034 Scenario: release reset -> INIT for 1 cycle, then phases 1,2,3,4,5,6 lasting 5,2,1,4,2,1 cycles, then back to 1.
REQ-035 Scenario: pulse ped_req for 1 cycle during G1R2 (TLC_PED_REQ_EN defined) -> after AR2, phase=7 with ped_walk=1 for 3 cycles, then G1R2, and the next cycle has no WALK.
REQ-036 Scenario: hold night_mode=1 from mid-R1G2 -> after AR2, yellows follow 1,1,0,0,1,1; drop night_mode -> AR1 for 1 cycle, then R1G2.
REQ-037 Scenario: assert reset_n=0 for 1 cycle during Y1R2 at count 1 -> outputs are 010/010 immediately, not waiting for a clock edge, then a full INIT-first sequence follows.
REQ-038 Scenario: assert night_mode and ped_req together before the end of AR2 -> FLASH is entered; clear night_mode -> AR1, R1G2, R1Y2, AR2, then WALK for 3 cycles.

Source files
------------

// File: rtl/traffic_light_ctrl_param.sv
// Two-road traffic light: G/Y/all-red cycle, night-mode flashing yellow, optional pedestrian WALK phase.
// Latency: lamps, phase and ped_walk are registered from the next state, so they change on the state's own edge.
// Backpressure: none; night_mode is sampled at AR1/AR2/flash-half-period ends, ped_req every cycle.
// Optional pedestrian feature: define TLC_PED_REQ_EN.
module traffic_light_ctrl_param #(
   parameter int CNT_W    = 12,
   parameter int T_GREEN1 = 2500,
   parameter int T_GREEN2 = 2250,
   parameter int T_YELLOW = 250,
   parameter int T_ALLRED = 50,
   parameter int T_WALK   = 400,
   parameter int T_FLASH  = 500
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       night_mode,
   input  logic       ped_req,
   output logic [2:0] light1,
   output logic [2:0] light2,
   output logic       ped_walk,
   output logic [2:0] phase
);

   // Every duration must be non-zero and fit in the phase counter.
   localparam longint LIMIT = longint'(1) << CNT_W;
   localparam bit BAD_PARAM =
      (T_GREEN1 <= 0) || (longint'(T_GREEN1) >= LIMIT) ||
      (T_GREEN2 <= 0) || (longint'(T_GREEN2) >= LIMIT) ||
      (T_YELLOW <= 0) || (longint'(T_YELLOW) >= LIMIT) ||
      (T_ALLRED <= 0) || (longint'(T_ALLRED) >= LIMIT) ||
      (T_WALK   <= 0) || (longint'(T_WALK)   >= LIMIT) ||
      (T_FLASH  <= 0) || (longint'(T_FLASH)  >= LIMIT);

   if (BAD_PARAM) begin : g_bad_param
      $error("traffic_light_ctrl_param: every T_* must lie in 1 .. 2**CNT_W-1");
   end

   localparam logic [CNT_W-1:0] T_G1_C = CNT_W'(T_GREEN1);
   localparam logic [CNT_W-1:0] T_G2_C = CNT_W'(T_GREEN2);
   localparam logic [CNT_W-1:0] T_Y_C  = CNT_W'(T_YELLOW);
   localparam logic [CNT_W-1:0] T_AR_C = CNT_W'(T_ALLRED);
   localparam logic [CNT_W-1:0] T_W_C  = CNT_W'(T_WALK);
   localparam logic [CNT_W-1:0] T_F_C  = CNT_W'(T_FLASH);

   // Low three bits are the external phase code; FLASH aliases INIT's code 0.
   typedef enum logic [3:0] {
      ST_INIT  = 4'd0,
      ST_G1R2  = 4'd1,
      ST_Y1R2  = 4'd2,
      ST_AR1   = 4'd3,
      ST_R1G2  = 4'd4,
      ST_R1Y2  = 4'd5,
      ST_AR2   = 4'd6,
      ST_WALK  = 4'd7,
      ST_FLASH = 4'd8
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] t_cur;
   logic             done;
   logic             lit_q, lit_d;
   logic             go_walk;
   logic             ped_pend;
   logic [2:0]       light1_q, light1_d;
   logic [2:0]       light2_q, light2_d;
   logic [2:0]       phase_q;

   // Duration of the current state; INIT uses 0 so it ends on its first cycle (count is 0 there).
   always_comb begin
      t_cur = '0;
      case (state_q)
         ST_G1R2:          t_cur = T_G1_C;
         ST_Y1R2, ST_R1Y2: t_cur = T_Y_C;
         ST_AR1, ST_AR2:   t_cur = T_AR_C;
         ST_R1G2:          t_cur = T_G2_C;
         ST_WALK:          t_cur = T_W_C;
         ST_FLASH:         t_cur = T_F_C;
         default:          t_cur = '0;
      endcase
   end

   assign done = (count_q == t_cur);

   // Next state and phase counter: count runs 1..T, reloads to 1 on every state (or half-period) exit.
   always_comb begin
      state_d = state_q;
      count_d = count_q + CNT_W'(1);
      go_walk = 1'b0;
      if (done) begin
         count_d = CNT_W'(1);
         case (state_q)
            ST_INIT:  state_d = ST_G1R2;
            ST_G1R2:  state_d = ST_Y1R2;
            ST_Y1R2:  state_d = ST_AR1;
            ST_AR1:   state_d = night_mode ? ST_FLASH : ST_R1G2;
            ST_R1G2:  state_d = ST_R1Y2;
            ST_R1Y2:  state_d = ST_AR2;
            ST_AR2: begin
               // Night mode beats a pending pedestrian request; the request stays latched.
               if (night_mode) begin
                  state_d = ST_FLASH;
               end else if (ped_pend) begin
                  state_d = ST_WALK;
                  go_walk = 1'b1;
               end else begin
                  state_d = ST_G1R2;
               end
            end
            ST_WALK:  state_d = ST_G1R2;
            ST_FLASH: state_d = night_mode ? ST_FLASH : ST_AR1;
            default:  state_d = ST_INIT;
         endcase
      end
   end

   // Flash yellow phase: lit on entry, toggled at each half-period end, cleared outside FLASH.
   always_comb begin
      lit_d = 1'b0;
      if (state_d == ST_FLASH) begin
         lit_d = (state_q != ST_FLASH) ? 1'b1 : (lit_q ^ done);
      end
   end

   // Moore lamp decode of the next state, {red,yellow,green} per road.
   always_comb begin
      light1_d = 3'b010;
      light2_d = 3'b010;
      case (state_d)
         ST_G1R2:                 begin light1_d = 3'b001; light2_d = 3'b100; end
         ST_Y1R2:                 begin light1_d = 3'b010; light2_d = 3'b100; end
         ST_AR1, ST_AR2, ST_WALK: begin light1_d = 3'b100; light2_d = 3'b100; end
         ST_R1G2:                 begin light1_d = 3'b100; light2_d = 3'b001; end
         ST_R1Y2:                 begin light1_d = 3'b100; light2_d = 3'b010; end
         ST_FLASH: begin
            light1_d = lit_d ? 3'b010 : 3'b000;
            light2_d = lit_d ? 3'b010 : 3'b000;
         end
         default:                 begin light1_d = 3'b010; light2_d = 3'b010; end
      endcase
   end

   // State, counter and registered outputs; reset forces INIT with both yellows lit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_INIT;
         count_q  <= '0;
         lit_q    <= 1'b0;
         light1_q <= 3'b010;
         light2_q <= 3'b010;
         phase_q  <= 3'd0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         lit_q    <= lit_d;
         light1_q <= light1_d;
         light2_q <= light2_d;
         phase_q  <= state_d[2:0];
      end
   end

   assign light1 = light1_q;
   assign light2 = light2_q;
   assign phase  = phase_q;

`ifdef TLC_PED_REQ_EN
   logic ped_pend_q, ped_pend_d;
   logic walk_q;

   // Hold a pedestrian request until an AR2 exit serves it; requests during WALK are dropped.
   always_comb begin
      ped_pend_d = (ped_pend_q & ~go_walk) | (ped_req & (state_q != ST_WALK));
   end

   // Pedestrian latch and registered walk lamp.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ped_pend_q <= 1'b0;
         walk_q     <= 1'b0;
      end else begin
         ped_pend_q <= ped_pend_d;
         walk_q     <= (state_d == ST_WALK);
      end
   end

   assign ped_pend = ped_pend_q;
   assign ped_walk = walk_q;
`else
   // Pedestrian feature compiled out: request ignored, WALK never entered.
   logic unused_ped;
   assign unused_ped = ped_req ^ go_walk;
   assign ped_pend   = 1'b0;
   assign ped_walk   = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Bench for traffic_light_ctrl_param with small timing parameters.
// Directed scenarios plus randomized night/ped/reset stimulus against a countdown reference model.
// Pedestrian checks follow TLC_PED_REQ_EN, matching the design build.
module tb_traffic_light_ctrl_param;

   localparam int TG1 = 5, TG2 = 4, TY = 2, TAR = 1, TW = 3, TF = 2;
   localparam logic [9:0] INIT_VEC = 10'b000_010_010_0;
`ifdef TLC_PED_REQ_EN
   localparam bit PED_EN = 1'b1;
`else
   localparam bit PED_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n, night_mode, ped_req;
   logic [2:0] light1, light2, phase;
   logic       ped_walk;
   logic [9:0] dut_vec;

   int errors = 0;
   int checks = 0;

   // Reference model: phase number, cycles left in it, flash mode and yellow lit flag, pending request.
   int m_phase, m_left;
   bit m_flash, m_lit, m_pend;

   traffic_light_ctrl_param #(
      .CNT_W(4), .T_GREEN1(TG1), .T_GREEN2(TG2), .T_YELLOW(TY),
      .T_ALLRED(TAR), .T_WALK(TW), .T_FLASH(TF)
   ) dut (
      .clk(clk), .reset_n(reset_n), .night_mode(night_mode), .ped_req(ped_req),
      .light1(light1), .light2(light2), .ped_walk(ped_walk), .phase(phase)
   );

   always #5 clk = ~clk;

   assign dut_vec = {phase, light1, light2, ped_walk};

   task automatic model_reset();
      m_phase = 0; m_left = 1; m_flash = 0; m_lit = 0; m_pend = 0;
   endtask

   task automatic enter_flash();
      m_flash = 1; m_lit = 1; m_phase = 0; m_left = TF;
   endtask

   task automatic model_step(input bit n, input bit p);
      bit go_walk;
      bit req;
      go_walk = 0;
      req = PED_EN && p && !(m_phase == 7 && !m_flash);
      if (m_left > 1) begin
         m_left--;
      end else if (m_flash) begin
         if (n) begin m_lit = !m_lit; m_left = TF; end
         else begin m_flash = 0; m_lit = 0; m_phase = 3; m_left = TAR; end
      end else begin
         case (m_phase)
            0: begin m_phase = 1; m_left = TG1; end
            1: begin m_phase = 2; m_left = TY; end
            2: begin m_phase = 3; m_left = TAR; end
            3: if (n) enter_flash(); else begin m_phase = 4; m_left = TG2; end
            4: begin m_phase = 5; m_left = TY; end
            5: begin m_phase = 6; m_left = TAR; end
            6: begin
               if (n) enter_flash();
               else if (m_pend) begin m_phase = 7; m_left = TW; go_walk = 1; end
               else begin m_phase = 1; m_left = TG1; end
            end
            default: begin m_phase = 1; m_left = TG1; end
         endcase
      end
      m_pend = (m_pend && !go_walk) || req;
   endtask

   function automatic logic [9:0] exp_vec();
      logic [2:0] l1, l2;
      l1 = 3'b010; l2 = 3'b010;
      if (m_flash) begin
         l1 = m_lit ? 3'b010 : 3'b000; l2 = l1;
      end else begin
         case (m_phase)
            1:       begin l1 = 3'b001; l2 = 3'b100; end
            2:       begin l1 = 3'b010; l2 = 3'b100; end
            3, 6, 7: begin l1 = 3'b100; l2 = 3'b100; end
            4:       begin l1 = 3'b100; l2 = 3'b001; end
            5:       begin l1 = 3'b100; l2 = 3'b010; end
            default: begin l1 = 3'b010; l2 = 3'b010; end
         endcase
      end
      return {3'(m_phase), l1, l2, (m_phase == 7 && !m_flash)};
   endfunction

   // Drive inputs for one cycle, advance the model at the edge, return at the following negedge.
   task automatic tick(input bit n, input bit p);
      night_mode = n; ped_req = p;
      @(posedge clk);
      model_step(n, p);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 0; night_mode = 0; ped_req = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (dut_vec !== INIT_VEC) begin errors++; $display("FAIL reset_hold: got %b want %b", dut_vec, INIT_VEC); end
      model_reset();
      reset_n = 1;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_release: got %b want %b", dut_vec, exp_vec()); end
   endtask

   task automatic test_normal_cycle();
      int seq_ph[7];
      int seq_len[7];
      seq_ph  = '{1, 2, 3, 4, 5, 6, 1};
      seq_len = '{5, 2, 1, 4, 2, 1, 1};
      for (int k = 0; k < 7; k++) begin
         for (int j = 0; j < seq_len[k]; j++) begin
            tick(0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL normal_model: got %b want %b", dut_vec, exp_vec()); end
            checks++;
            if (phase !== 3'(seq_ph[k])) begin errors++; $display("FAIL normal_seq: step %0d got phase %0d want %0d", k, phase, seq_ph[k]); end
         end
      end
   endtask

   task automatic test_ped();
      int guard;
      int walk_len;
      tick(0, 1);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL ped_pulse: got %b want %b", dut_vec, exp_vec()); end
`ifdef TLC_PED_REQ_EN
      guard = 0;
      while (phase !== 3'd7 && guard < 40) begin
         tick(0, 0); guard++;
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL ped_model: got %b want %b", dut_vec, exp_vec()); end
      end
      checks++;
      if (phase !== 3'd7) begin errors++; $display("FAIL ped_reach_walk: got phase %0d want 7", phase); end
      walk_len = 0;
      while (phase === 3'd7 && ped_walk === 1'b1 && walk_len < 10) begin
         tick(0, 0); walk_len++;
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL ped_walk_model: got %b want %b", dut_vec, exp_vec()); end
      end
      checks++;
      if (walk_len !== 3) begin errors++; $display("FAIL ped_walk_len: got %0d want 3", walk_len); end
      checks++;
      if (phase !== 3'd1) begin errors++; $display("FAIL ped_after_walk: got phase %0d want 1", phase); end
      tick(0, 0);
      checks++;
      if (phase === 3'd7 || ped_walk !== 1'b0) begin errors++; $display("FAIL ped_no_rewalk: got phase %0d walk %b want phase 1 walk 0", phase, ped_walk); end
`else
      for (int i = 0; i < 30; i++) begin
         tick(0, 0);
         checks++;
         if (ped_walk !== 1'b0 || phase === 3'd7) begin errors++; $display("FAIL ped_disabled: got phase %0d walk %b want no WALK", phase, ped_walk); end
      end
`endif
   endtask

   task automatic test_night();
      int guard;
      logic [5:0] ys;
      guard = 0;
      while (phase !== 3'd4 && guard < 40) begin
         tick(0, 0); guard++;
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL night_pre_model: got %b want %b", dut_vec, exp_vec()); end
      end
      checks++;
      if (phase !== 3'd4) begin errors++; $display("FAIL night_reach_r1g2: got phase %0d want 4", phase); end
      guard = 0;
      do begin
         tick(1, 0); guard++;
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL night_enter_model: got %b want %b", dut_vec, exp_vec()); end
      end while (!(phase === 3'd0 && light1 === 3'b010) && guard < 20);
      checks++;
      if (phase !== 3'd0 || light1 !== 3'b010) begin errors++; $display("FAIL night_enter_flash: got %b want phase 0 yellows lit", dut_vec); end
      ys = {5'b0, light1[1]};
      for (int i = 0; i < 5; i++) begin
         tick(1, 0);
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL night_flash_model: got %b want %b", dut_vec, exp_vec()); end
         ys = {ys[4:0], light1[1]};
      end
      checks++;
      if (ys !== 6'b110011) begin errors++; $display("FAIL night_yellow_pattern: got %b want 110011", ys); end
      tick(0, 0);
      checks++;
      if (phase !== 3'd3 || dut_vec !== exp_vec()) begin errors++; $display("FAIL night_exit_ar1: got %b want phase 3 (%b)", dut_vec, exp_vec()); end
      tick(0, 0);
      checks++;
      if (phase !== 3'd4 || dut_vec !== exp_vec()) begin errors++; $display("FAIL night_exit_r1g2: got %b want phase 4 (%b)", dut_vec, exp_vec()); end
   endtask

   task automatic test_reset_mid();
      int guard;
      guard = 0;
      while (phase !== 3'd2 && guard < 40) begin
         tick(0, 0); guard++;
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL rmid_pre_model: got %b want %b", dut_vec, exp_vec()); end
      end
      checks++;
      if (phase !== 3'd2) begin errors++; $display("FAIL rmid_reach_y1r2: got phase %0d want 2", phase); end
      #2 reset_n = 0;
      #1;
      checks++;
      if (dut_vec !== INIT_VEC) begin errors++; $display("FAIL rmid_async: got %b want %b", dut_vec, INIT_VEC); end
      model_reset();
      @(negedge clk);
      checks++;
      if (dut_vec !== INIT_VEC) begin errors++; $display("FAIL rmid_held: got %b want %b", dut_vec, INIT_VEC); end
      reset_n = 1;
      for (int i = 0; i < 16; i++) begin
         tick(0, 0);
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL rmid_seq: cycle %0d got %b want %b", i, dut_vec, exp_vec()); end
      end
   endtask

   task automatic test_night_ped();
      int guard;
      int run_ph[$];
      int run_len[$];
      int e_ph[$];
      int e_len[$];
`ifdef TLC_PED_REQ_EN
      e_ph = '{3, 4, 5, 6, 7, 1};
      e_len = '{1, 4, 2, 1, 3};
`else
      e_ph = '{3, 4, 5, 6, 1};
      e_len = '{1, 4, 2, 1};
`endif
      guard = 0;
      while (phase !== 3'd5 && guard < 40) begin
         tick(0, 0); guard++;
      end
      tick(1, 1);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL np_req_model: got %b want %b", dut_vec, exp_vec()); end
      guard = 0;
      while (!(phase === 3'd0 && light1 === 3'b010) && guard < 20) begin
         tick(1, 0); guard++;
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL np_enter_model: got %b want %b", dut_vec, exp_vec()); end
      end
      checks++;
      if (phase !== 3'd0 || light1 !== 3'b010) begin errors++; $display("FAIL np_flash: got %b want phase 0 yellows lit", dut_vec); end
      for (int i = 0; i < 20; i++) begin
         tick(0, 0);
         checks++;
         if (dut_vec !== exp_vec()) begin errors++; $display("FAIL np_model: got %b want %b", dut_vec, exp_vec()); end
         if (phase !== 3'd0) begin
            if (run_ph.size() > 0 && run_ph[run_ph.size()-1] == int'(phase))
               run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
            else begin
               run_ph.push_back(int'(phase)); run_len.push_back(1);
            end
         end
      end
      for (int k = 0; k < e_ph.size(); k++) begin
         checks++;
         if (k >= run_ph.size() || run_ph[k] != e_ph[k] || (k < e_len.size() && run_len[k] != e_len[k]))
            begin errors++; $display("FAIL np_runs: run %0d got phase %0d len %0d want phase %0d", k,
               (k < run_ph.size()) ? run_ph[k] : -1, (k < run_len.size()) ? run_len[k] : -1, e_ph[k]); end
      end
   endtask

   task automatic test_random();
      bit n;
      bit p;
      n = 0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 59) == 0) n = !n;
         p = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 249) == 0) begin
            night_mode = n; ped_req = 0;
            #2 reset_n = 0;
            #1;
            checks++;
            if (dut_vec !== INIT_VEC) begin errors++; $display("FAIL rand_reset: got %b want %b", dut_vec, INIT_VEC); end
            model_reset();
            @(negedge clk);
            reset_n = 1;
         end else begin
            tick(n, p);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL rand_model: cycle %0d got %b want %b", i, dut_vec, exp_vec()); end
         end
      end
   endtask

   initial begin
      reset_n = 0; night_mode = 0; ped_req = 0;
      model_reset();
      test_reset();
      test_normal_cycle();
      test_ped();
      test_night();
      test_reset_mid();
      test_night_ped();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
